// File: rtl/data_stack_unit.sv
// Hardware data stack beside the execute phase: owns pointer, depth and
// error flags over a single-port RAM with registered read.
module data_stack_unit #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push_req,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_req,
    input  logic             clear_err,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             err_overflow,
    output logic             err_underflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PUSH_ACK,
        S_POP_WAIT,
        S_POP_ACK
    } state_t;

    state_t           state_q, state_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             pop_ok_q, pop_ok_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             take_push;
    logic             take_pop;
    logic             mem_we;
    logic             mem_re;
    logic [AW-1:0]    mem_addr;
    logic [AW:0]      count_m1;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign take_push = (state_q == S_IDLE) && push_req;
    assign take_pop  = (state_q == S_IDLE) && !push_req && pop_req;
    assign count_m1  = count_q - (AW+1)'(1);

    // One RAM access per cycle: write on push accept, read on pop accept.
    assign mem_we   = take_push && !full;
    assign mem_re   = take_pop && !empty;
    assign mem_addr = take_push ? count_q[AW-1:0] : count_m1[AW-1:0];

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_addr] <= push_data;
        end else if (mem_re) begin
            rdata_q <= mem[mem_addr];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (take_push) begin
                    state_d = S_PUSH_ACK;
                end else if (take_pop) begin
                    state_d = S_POP_WAIT;
                end
            end
            S_PUSH_ACK: state_d = S_IDLE;
            S_POP_WAIT: state_d = S_POP_ACK;
            S_POP_ACK:  state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_PUSH_ACK) || (state_q == S_POP_ACK);
    end

    // Error flags: clear_err drops them, but a same-edge error wins.
    always_comb begin
        count_d    = count_q;
        ovf_d      = ovf_q & ~clear_err;
        udf_d      = udf_q & ~clear_err;
        pop_ok_d   = pop_ok_q;
        pop_data_d = pop_data_q;
        if (take_push) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + (AW+1)'(1);
            end
        end
        if (take_pop) begin
            pop_ok_d = !empty;
            if (empty) begin
                udf_d = 1'b1;
            end else begin
                count_d = count_m1;
            end
        end
        if (state_q == S_POP_WAIT) begin
            pop_data_d = pop_ok_q ? rdata_q : '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q    <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            pop_ok_q   <= 1'b0;
            pop_data_q <= '0;
        end else begin
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            pop_ok_q   <= pop_ok_d;
            pop_data_q <= pop_data_d;
        end
    end

    assign count         = count_q;
    assign pop_data      = pop_data_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = udf_q;

endmodule

// File: tb/tb_data_stack_unit.sv
// Directed bench for data_stack_unit: LIFO order, done timing,
// overflow/underflow flags, push priority and mid-pop reset.
module tb_data_stack_unit;

    localparam int WIDTH = 32;
    localparam int DEPTH = 128;
    localparam int AW    = 7;

    logic             CLK;
    logic             RST_N;
    logic             push_req;
    logic [WIDTH-1:0] push_data;
    logic             pop_req;
    logic             clear_err;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] pop_data;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             err_overflow;
    logic             err_underflow;

    int total = 0;
    int bad   = 0;

    data_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .push_req     (push_req),
        .push_data    (push_data),
        .pop_req      (pop_req),
        .clear_err    (clear_err),
        .busy         (busy),
        .done         (done),
        .pop_data     (pop_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the unit idle; returns at a negedge, idle.
    task automatic do_push(input logic [WIDTH-1:0] d);
        push_req  = 1'b1;
        push_data = d;
        @(negedge CLK);
        push_req = 1'b0;
        chk("push_done", 64'(done), 64'd1);
        @(negedge CLK);
        chk("push_done_end", 64'(done), 64'd0);
    endtask

    task automatic do_pop(input logic [WIDTH-1:0] exp);
        pop_req = 1'b1;
        @(negedge CLK);
        pop_req = 1'b0;
        chk("pop_wait_nodone", 64'(done), 64'd0);
        @(negedge CLK);
        chk("pop_done", 64'(done), 64'd1);
        chk("pop_data", 64'(pop_data), 64'(exp));
        @(negedge CLK);
        chk("pop_done_end", 64'(done), 64'd0);
    endtask

    initial begin
        RST_N     = 1'b0;
        push_req  = 1'b0;
        push_data = '0;
        pop_req   = 1'b0;
        clear_err = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_popdata", 64'(pop_data), 64'd0);
        chk("rst_flags", 64'({err_overflow, err_underflow}), 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // Basic LIFO order
        do_push(32'h11);
        chk("cnt1", 64'(count), 64'd1);
        do_push(32'h22);
        do_push(32'h33);
        chk("cnt3", 64'(count), 64'd3);
        do_pop(32'h33);
        chk("cnt2", 64'(count), 64'd2);
        do_pop(32'h22);
        chk("cnt1b", 64'(count), 64'd1);
        do_pop(32'h11);
        chk("cnt0", 64'(count), 64'd0);
        chk("empty_end", 64'(empty), 64'd1);
        chk("no_flags", 64'({err_overflow, err_underflow}), 64'd0);

        // Fill, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            do_push(32'h100 + 32'(i));
        end
        chk("full", 64'(full), 64'd1);
        chk("cnt_full", 64'(count), 64'd128);
        do_push(32'hDEAD);
        chk("cnt_sat", 64'(count), 64'd128);
        chk("ovf", 64'(err_overflow), 64'd1);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            do_pop(32'h100 + 32'(i));
        end
        chk("drained", 64'(count), 64'd0);

        // Underflow, then clear
        do_pop(32'h0);
        chk("udf", 64'(err_underflow), 64'd1);
        chk("cnt_udf", 64'(count), 64'd0);
        clear_err = 1'b1;
        @(negedge CLK);
        clear_err = 1'b0;
        chk("cleared", 64'({err_overflow, err_underflow}), 64'd0);

        // Push priority, held pop accepted when idle
        do_push(32'h55);
        push_req  = 1'b1;
        pop_req   = 1'b1;
        push_data = 32'h66;
        @(negedge CLK);
        push_req = 1'b0;
        chk("prio_done", 64'(done), 64'd1);
        chk("prio_cnt", 64'(count), 64'd2);
        @(negedge CLK);
        chk("prio_idle", 64'(busy), 64'd0);
        @(negedge CLK);
        pop_req = 1'b0;
        chk("held_pop_cnt", 64'(count), 64'd1);
        chk("held_pop_busy", 64'(busy), 64'd1);
        @(negedge CLK);
        chk("held_pop_done", 64'(done), 64'd1);
        chk("held_pop_data", 64'(pop_data), 64'h66);
        @(negedge CLK);
        do_pop(32'h55);

        // Reset during POP_WAIT
        do_push(32'h77);
        do_push(32'h88);
        pop_req = 1'b1;
        @(negedge CLK);
        pop_req = 1'b0;
        chk("mid_busy", 64'(busy), 64'd1);
        RST_N = 1'b0;
        #1;
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_done", 64'(done), 64'd0);
        chk("ar_count", 64'(count), 64'd0);
        chk("ar_popdata", 64'(pop_data), 64'd0);
        chk("ar_flags", 64'({err_overflow, err_underflow}), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("ar_nodone", 64'(done), 64'd0);
        end
        do_push(32'h99);
        chk("ar_cnt1", 64'(count), 64'd1);
        do_pop(32'h99);
        chk("ar_cnt0", 64'(count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_stack_unit.md
Name: data_stack_unit

Overview:
- Hardware data stack that sits beside the CPU core's execute phase.
- The core issues push and pop requests here instead of indexing its own stack array, which removes stack-pointer arithmetic from the core's decode logic.
- Storage is a single-port, block-RAM-friendly array with a registered read. The unit owns the stack pointer, depth count and error flags.
- The core waits for a one-cycle done pulse before advancing its instruction phase.

Parameters:
- WIDTH, 32: data word width in bits.
- DEPTH, 128: number of stack entries; must be a power of two, minimum 2.
- AW, log2(DEPTH): address width; derived, do not override.

Ports:
- CLK  in  1: system clock (16 MHz); all state changes on its rising edge.
- RST_N  in  1: asynchronous active-low reset. Asserts immediately; deassertion is synchronised externally.
- push_req  in  1: request to push push_data. Sampled only when busy=0.
- push_data  in  WIDTH: word to push. Captured on the accepting edge.
- pop_req  in  1: request to pop the top entry. Sampled only when busy=0.
- clear_err  in  1: synchronous clear of both sticky error flags.
- busy  out  1: high while an operation is in progress; requests are ignored while high.
- done  out  1: one-cycle pulse marking completion of the accepted operation.
- pop_data  out  WIDTH: popped word. Valid in the done cycle of a pop; holds its value until the next pop's done.
- count  out  AW+1: current number of entries, 0..DEPTH.
- full  out  1: count==DEPTH (combinational from count).
- empty  out  1: count==0 (combinational from count).
- err_overflow  out  1: sticky; set by a push while full.
- err_underflow  out  1: sticky; set by a pop while empty.

Behaviour:
- Reset values (RST_N low, asynchronous): state=IDLE, busy=0, done=0, pop_data=0, count=0, err_overflow=0, err_underflow=0. RAM contents are not cleared and are don't-care.
- FSM states: IDLE, PUSH_ACK, POP_WAIT, POP_ACK. busy = (state != IDLE). done = (state==PUSH_ACK or state==POP_ACK).
- IDLE, accepting edge N:
  - If push_req=1: the request is accepted as a push.
  - Else if pop_req=1: the request is accepted as a pop.
  - Push priority: when both are high, the push is taken and the pop is dropped. The requester must re-present the pop.
- Push accepted at edge N, not full:
  - mem[count] <= push_data at edge N; count <= count+1 at edge N.
  - state -> PUSH_ACK, so done=1 during cycle N+1. Returns to IDLE at edge N+1.
  - Total occupancy 2 cycles.
- Push while full:
  - No RAM write; count unchanged; err_overflow <= 1 at edge N.
  - Still goes through PUSH_ACK, so done still pulses.
- Pop accepted at edge N, not empty:
  - RAM read address = count-1 presented at edge N; count <= count-1 at edge N.
  - state -> POP_WAIT (RAM registered read); read data is available at edge N+1.
  - pop_data <= RAM output at edge N+1; state -> POP_ACK, done=1 during cycle N+2. Returns to IDLE at edge N+2.
  - Total occupancy 3 cycles.
- Pop while empty:
  - count unchanged; err_underflow <= 1 at edge N.
  - pop_data <= 0 at edge N+1; done still pulses in cycle N+2.
- Requests arriving while busy=1 are ignored and not queued. A request held high is re-sampled at the first edge where busy=0.
- clear_err=1 clears both flags at the next edge. If an error-setting event occurs on the same edge, the set wins.
- count never wraps: saturates at DEPTH (overflow path) and at 0 (underflow path).
- Reset mid-operation: the FSM aborts to IDLE.
  - An in-flight pop's data is lost; done does not pulse.
  - A push already written at the accepting edge is discarded logically, since count resets to 0.
- RAM is inferred as a single-port synchronous array. At most one access per cycle: a write at push acceptance, a read at pop acceptance.

Test Plan:
- Push 0x11, 0x22, 0x33, each waiting for done, then 3 pops -> pop_data 0x33, 0x22, 0x11 in the respective done cycles. count goes 3,2,1,0; empty=1 at end; no error flags.
- Timing: push accepted at edge N -> done high exactly in cycle N+1. Pop accepted at edge M -> done high exactly in cycle M+2. Neither op's done lasts more than one cycle.
- Push 128 values (full=1, count=128), then push 0xDEAD -> done pulses, count stays 128, err_overflow=1. Subsequent pop returns value #128, not 0xDEAD.
- Pop on empty -> done in cycle N+2, pop_data=0, err_underflow=1. Assert clear_err one cycle -> both flags 0.
- Assert push_req and pop_req together with count=1 -> push taken, count=2. Pop_req held high is then accepted when busy falls; it pops the just-pushed word.
- Pulse RST_N low during POP_WAIT -> busy, done, count, flags all 0 immediately, with no done pulse afterwards. A push following reset lands at address 0.
